// File: rtl/crush_pkg.sv
// Shared constants and helpers for the sample crusher: LFSR definition and the
// bit-depth quantiser (mask-based floor toward -inf on two's complement samples).
package crush_pkg;

  localparam int MAX_DIV_W = 16;
  localparam int MAX_W     = 64;
  localparam int LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef logic [MAX_W-1:0] wide_t;

  // Ones in the retained MSBs; all ones when keep is 0 or covers the full width.
  function automatic wide_t crush_mask(input int unsigned width, input int unsigned keep);
    if (keep == 0 || keep >= width) return '1;
    return ~((MAX_W'(1) << (width - keep)) - MAX_W'(1));
  endfunction

  // Clearing low bits of a two's complement value floors toward -inf.
  function automatic wide_t quantise(input wide_t x, input int unsigned width,
                                     input int unsigned keep);
    return x & crush_mask(width, keep);
  endfunction

endpackage

// File: rtl/crush_lfsr.sv
// 16-bit Galois LFSR used as the dither source; steps once per advance pulse.
module crush_lfsr
  import crush_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       state <= LFSR_SEED;
    else if (advance) state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/sample_crusher.sv
// Multi-channel bit-crusher: runtime sample-and-hold rate reduction plus MSB truncation.
// Optional dither before truncation when CRUSH_DITHER_EN is defined.
module sample_crusher
  import crush_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int DIV_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic [$clog2(WIDTH+1)-1:0] keep_bits,
  output logic                       out_valid,
  output logic [CHANNELS*WIDTH-1:0]  out_data
);

  typedef logic signed [WIDTH-1:0] sample_t;

  logic [DIV_W-1:0]                 cnt, div_eff;
  logic [CHANNELS-1:0][WIDTH-1:0]   hold, quant, samp;
  logic [WIDTH-1:0]                 mask;

  assign samp    = in_data;
  assign div_eff = (rate_div == '0) ? DIV_W'(1) : rate_div;
  assign mask    = WIDTH'(crush_mask(WIDTH, int'(keep_bits)));

`ifdef CRUSH_DITHER_EN
  logic [LFSR_W-1:0] lfsr;

  crush_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (in_valid),
    .state   (lfsr)
  );
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sample_t dsamp;
`ifdef CRUSH_DITHER_EN
    localparam int ROT = c % LFSR_W;
    logic [2*LFSR_W-1:0] rot2;
    sample_t             dith, sum;
    assign rot2 = {lfsr, lfsr} >> ROT;
    // ~mask is zero whenever truncation is off, so dither vanishes with it
    assign dith = WIDTH'(rot2[LFSR_W-1:0]) & ~mask;
    assign sum  = samp[c] + dith;
    assign dsamp = (!samp[c][WIDTH-1] && sum[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}} : sum;
`else
    assign dsamp = samp[c];
`endif
    assign quant[c] = WIDTH'(quantise(MAX_W'(dsamp), WIDTH, int'(keep_bits)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      hold      <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (!enable) begin
          out_data <= in_data;
          cnt      <= '0;
        end else begin
          if (cnt == '0) begin
            hold     <= quant;
            out_data <= quant;
          end else begin
            out_data <= hold;
          end
          // >= so a lowered rate_div wraps immediately instead of running to 2**DIV_W
          cnt <= (cnt >= div_eff - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule
